// File: rtl/set_key_ctrl_if.sv
// Key inputs and adjustment/status outputs of the time-setting controller.
// The master side drives the raw push-buttons and the slave side (the controller) drives the results.
interface set_key_ctrl_if;
    logic       KEY_MODE;
    logic       KEY_UP;
    logic       KEY_DOWN;
    logic       H_UP;
    logic       H_DOWN;
    logic       M_UP;
    logic       M_DOWN;
    logic       S_UP;
    logic       S_DOWN;
    logic       SET_EN;
    logic [1:0] FIELD;

    modport master (
        output KEY_MODE, KEY_UP, KEY_DOWN,
        input  H_UP, H_DOWN, M_UP, M_DOWN, S_UP, S_DOWN, SET_EN, FIELD
    );

    modport slave (
        input  KEY_MODE, KEY_UP, KEY_DOWN,
        output H_UP, H_DOWN, M_UP, M_DOWN, S_UP, S_DOWN, SET_EN, FIELD
    );
endinterface

// File: rtl/set_key_ctrl.sv
// Clock time-setting controller: synchronizes and debounces three push-buttons, steps a
// RUN/SET_H/SET_M/SET_S mode FSM with inactivity timeout, and drives registered adjust levels.
module set_key_ctrl #(
    parameter int DEB_CNT = 20,
    parameter int TIMEOUT = 10000
) (
    input  logic             CP,
    input  logic             CR,
    set_key_ctrl_if.slave    bus,
    output logic [1:0]       o_dbg_state
);
    localparam int DW = (DEB_CNT > 1) ? $clog2(DEB_CNT) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        RUN   = 2'b00,
        SET_H = 2'b01,
        SET_M = 2'b10,
        SET_S = 2'b11
    } state_t;

    // Key bit order everywhere: [0] MODE, [1] UP, [2] DOWN.
    logic [2:0]    w_raw;
    logic [2:0]    r_sync1;
    logic [2:0]    r_sync2;
    logic [2:0]    r_deb;
    logic [DW-1:0] r_deb_cnt [3];

    state_t        r_state;
    state_t        w_next;
    logic [TW-1:0] r_to_cnt;
    logic [TW-1:0] w_to_nxt;
    logic          r_mode_d;
    logic          r_lock;
    logic          w_lock_nxt;
    logic          w_mode_press;
    logic          w_inc;
    logic          w_dec;
    logic [5:0]    w_adj_nxt;
    logic [5:0]    r_adj;
    logic          r_set_en;
    logic [1:0]    r_field;

    assign w_raw = {bus.KEY_DOWN, bus.KEY_UP, bus.KEY_MODE};

    always_ff @(posedge CP or negedge CR) begin
        if (!CR) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_deb   <= '0;
            for (int k = 0; k < 3; k++) begin
                r_deb_cnt[k] <= '0;
            end
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
            for (int k = 0; k < 3; k++) begin
                if (r_sync2[k] == r_deb[k]) begin
                    r_deb_cnt[k] <= '0;
                end else if (r_deb_cnt[k] == DW'(DEB_CNT - 1)) begin
                    r_deb[k]     <= ~r_deb[k];
                    r_deb_cnt[k] <= '0;
                end else begin
                    r_deb_cnt[k] <= r_deb_cnt[k] + 1'b1;
                end
            end
        end
    end

    assign w_mode_press = r_deb[0] & ~r_mode_d;

    always_ff @(posedge CP or negedge CR) begin
        if (!CR) begin
            r_state  <= RUN;
            r_to_cnt <= '0;
            r_mode_d <= 1'b0;
            r_lock   <= 1'b0;
            r_adj    <= '0;
            r_set_en <= 1'b0;
            r_field  <= 2'b00;
        end else begin
            r_state  <= w_next;
            r_to_cnt <= w_to_nxt;
            r_mode_d <= r_deb[0];
            r_lock   <= w_lock_nxt;
            r_adj    <= w_adj_nxt;
            r_set_en <= (w_next != RUN);
            r_field  <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_to_nxt  = r_to_cnt;
        w_adj_nxt = '0;

        if (r_state == RUN) begin
            w_to_nxt = '0;
        end else if ((|r_deb) || w_mode_press) begin
            w_to_nxt = '0;
        end else if (r_to_cnt == TW'(TIMEOUT - 1)) begin
            w_to_nxt = '0;
            w_next   = RUN;
        end else begin
            w_to_nxt = r_to_cnt + 1'b1;
        end

        // A mode press overrides any timeout decided above; SET_S wraps back to RUN.
        if (w_mode_press) begin
            w_next = state_t'(r_state + 2'd1);
        end

        // Any state change blocks adjustment until UP and DOWN are both seen debounced low.
        w_lock_nxt = (w_next != r_state) | (r_lock & (r_deb[1] | r_deb[2]));
        w_inc      = r_deb[1] & ~r_deb[2] & ~w_lock_nxt;
        w_dec      = r_deb[2] & ~r_deb[1] & ~w_lock_nxt;

        case (w_next)
            SET_H:   w_adj_nxt = {w_inc, w_dec, 4'b0000};
            SET_M:   w_adj_nxt = {2'b00, w_inc, w_dec, 2'b00};
            SET_S:   w_adj_nxt = {4'b0000, w_inc, w_dec};
            default: w_adj_nxt = '0;
        endcase
    end

    assign bus.H_UP    = r_adj[5];
    assign bus.H_DOWN  = r_adj[4];
    assign bus.M_UP    = r_adj[3];
    assign bus.M_DOWN  = r_adj[2];
    assign bus.S_UP    = r_adj[1];
    assign bus.S_DOWN  = r_adj[0];
    assign bus.SET_EN  = r_set_en;
    assign bus.FIELD   = r_field;
    assign o_dbg_state = r_state;
endmodule

// File: tb/tb_set_key_ctrl.sv
// Directed bench for set_key_ctrl with DEB_CNT=4, TIMEOUT=100; key changes reach the
// debounced level 6 edges after being driven and the registered outputs 7 edges after.
module tb_set_key_ctrl;
    logic       clk;
    logic       rst_n;
    logic [1:0] dbg_state;
    logic [5:0] adj;
    int         n_vec;
    int         n_miss;
    logic [1:0] exp_q[$];

    set_key_ctrl_if bus();

    set_key_ctrl #(
        .DEB_CNT (4),
        .TIMEOUT (100)
    ) dut (
        .CP          (clk),
        .CR          (rst_n),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    assign adj = {bus.H_UP, bus.H_DOWN, bus.M_UP, bus.M_DOWN, bus.S_UP, bus.S_DOWN};

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // driver: one clean mode press, then wait for the release to be debounced
    task automatic press_mode(input logic [1:0] exp_field);
        bus.KEY_MODE = 1'b1;
        step(7);
        check("mode_field", 32'(bus.FIELD), 32'(exp_field));
        check("mode_set_en", 32'(bus.SET_EN), 32'(exp_field != 2'b00));
        bus.KEY_MODE = 1'b0;
        step(8);
    endtask

    initial begin
        n_vec        = 0;
        n_miss       = 0;
        rst_n        = 1'b0;
        bus.KEY_MODE = 1'b0;
        bus.KEY_UP   = 1'b0;
        bus.KEY_DOWN = 1'b0;
        step(3);
        check("rst_field", 32'(bus.FIELD), 32'd0);
        check("rst_set_en", 32'(bus.SET_EN), 32'd0);
        check("rst_adj", 32'(adj), 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);
        rst_n = 1'b1;

        // glitch of 3 cycles is filtered
        bus.KEY_MODE = 1'b1;
        step(3);
        bus.KEY_MODE = 1'b0;
        step(10);
        check("glitch_field", 32'(bus.FIELD), 32'd0);
        check("glitch_state", 32'(dbg_state), 32'd0);

        // full mode cycle
        exp_q.push_back(2'b01);
        exp_q.push_back(2'b10);
        exp_q.push_back(2'b11);
        exp_q.push_back(2'b00);
        while (exp_q.size() > 0) begin
            press_mode(exp_q.pop_front());
        end

        // SET_M: hold UP for 50 cycles
        press_mode(2'b01);
        press_mode(2'b10);
        bus.KEY_UP = 1'b1;
        step(6);
        check("m_up_early", 32'(adj), 32'h00);
        step(1);
        check("m_up_on", 32'(adj), 32'h08);
        step(42);
        check("m_up_held", 32'(adj), 32'h08);
        step(1);
        bus.KEY_UP = 1'b0;
        step(6);
        check("m_up_rel_early", 32'(adj), 32'h08);
        step(1);
        check("m_up_off", 32'(adj), 32'h00);

        // UP and DOWN together cancel
        bus.KEY_UP   = 1'b1;
        bus.KEY_DOWN = 1'b1;
        step(7);
        check("m_both", 32'(adj), 32'h00);
        step(10);
        check("m_both_held", 32'(adj), 32'h00);
        bus.KEY_UP   = 1'b0;
        bus.KEY_DOWN = 1'b0;
        step(8);

        // DOWN held, then asynchronous reset mid-SET_M
        bus.KEY_DOWN = 1'b1;
        step(7);
        check("m_down", 32'(adj), 32'h04);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_adj", 32'(adj), 32'h00);
        check("async_field", 32'(bus.FIELD), 32'd0);
        check("async_set_en", 32'(bus.SET_EN), 32'd0);
        check("async_state", 32'(dbg_state), 32'd0);
        bus.KEY_MODE = 1'b1;
        step(3);
        rst_n = 1'b1;
        step(6);
        check("post_rst_field", 32'(bus.FIELD), 32'd0);
        check("post_rst_adj", 32'(adj), 32'h00);
        step(1);
        check("post_rst_held_mode", 32'(bus.FIELD), 32'd1);
        check("post_rst_down_locked", 32'(adj), 32'h00);
        bus.KEY_MODE = 1'b0;
        bus.KEY_DOWN = 1'b0;
        step(8);
        check("post_rst_idle", 32'(adj), 32'h00);

        // SET_H: UP held across a mode press must not carry into SET_M
        bus.KEY_UP = 1'b1;
        step(7);
        check("h_up", 32'(adj), 32'h20);
        bus.KEY_MODE = 1'b1;
        step(7);
        check("carry_field", 32'(bus.FIELD), 32'd2);
        check("carry_adj", 32'(adj), 32'h00);
        bus.KEY_MODE = 1'b0;
        step(10);
        check("carry_held", 32'(adj), 32'h00);
        bus.KEY_UP = 1'b0;
        step(8);
        check("carry_rel", 32'(adj), 32'h00);
        bus.KEY_UP = 1'b1;
        step(7);
        check("carry_repress", 32'(adj), 32'h08);
        bus.KEY_UP = 1'b0;
        step(8);

        // SET_S timeout: release debounced 6 edges after drive, RUN 100 edges after that
        press_mode(2'b11);
        step(97);
        check("to_before", 32'(bus.FIELD), 32'd3);
        step(1);
        check("to_field", 32'(bus.FIELD), 32'd0);
        check("to_set_en", 32'(bus.SET_EN), 32'd0);

        // mode press landing in the timeout cycle
        press_mode(2'b01);
        press_mode(2'b10);
        press_mode(2'b11);
        step(91);
        bus.KEY_MODE = 1'b1;
        step(6);
        check("race_before", 32'(bus.FIELD), 32'd3);
        step(1);
        check("race_field", 32'(bus.FIELD), 32'd0);
        bus.KEY_MODE = 1'b0;
        step(10);
        check("race_no_double", 32'(bus.FIELD), 32'd0);
        check("race_state", 32'(dbg_state), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/set_key_ctrl.md
SET_KEY_CTRL -- requirements
Module: set_key_ctrl

Interface
REQ-001 Parameter DEB_CNT, default 20: number of consecutive CP cycles a raw key level must hold before the debounced level changes.
REQ-002 Parameter TIMEOUT, default 10000: number of CP cycles with no debounced key activity in a set mode before automatic return to RUN.
REQ-003 CP  in  1  system/sample clock; all state changes on the rising edge.
REQ-004 CR  in  1  reset, asynchronous, active-low.
REQ-005 KEY_MODE  in  1  raw mode push-button, active-high, asynchronous and bouncy.
REQ-006 KEY_UP  in  1  raw increment push-button, active-high.
REQ-007 KEY_DOWN  in  1  raw decrement push-button, active-high.
REQ-008 H_UP, H_DOWN, M_UP, M_DOWN, S_UP, S_DOWN  out  1 each  registered adjustment levels for the hour, minute and second counters of the timing block.
REQ-009 SET_EN  out  1  high in any set mode, low in RUN.
REQ-010 FIELD  out  2  selected field: 00 RUN, 01 hour, 10 minute, 11 second, for display blinking.

Function
REQ-011 Each raw key SHALL pass through a 2-flop synchronizer before any other logic.
REQ-012 Each synchronized key SHALL have its own debounce counter: the counter resets to 0 whenever the synchronized level equals the debounced level; otherwise it increments, and at DEB_CNT-1 the debounced level toggles and the counter clears.
REQ-013 Debounced outputs SHALL reset to 0; a glitch shorter than DEB_CNT cycles SHALL never change a debounced level.
REQ-014 A mode press SHALL be a one-cycle rising-edge pulse of debounced KEY_MODE.
REQ-015 Mode FSM states SHALL be RUN, SET_H, SET_M, SET_S; each mode press advances RUN->SET_H->SET_M->SET_S->RUN.
REQ-016 In any set state, the timeout counter SHALL clear on any debounced key being high or any mode press, otherwise increment; on reaching TIMEOUT-1 the FSM SHALL go to RUN and the counter SHALL clear.
REQ-017 In RUN the timeout counter SHALL be held at 0.
REQ-018 If a mode press and a timeout occur in the same cycle, the mode press SHALL win.
REQ-019 Adjustment outputs SHALL be registered, with a change on them one CP cycle after the debounced key change that causes it.
REQ-020 In SET_H: H_UP = debounced UP and not debounced DOWN; H_DOWN = debounced DOWN and not debounced UP; SET_M and SET_S behave the same on the M_ and S_ pairs.
REQ-021 All six adjustment outputs SHALL be 0 in RUN, 0 for the non-selected fields, and 0 when UP and DOWN are both debounced high.
REQ-022 Adjustment outputs SHALL be levels, held for as long as the key is held; repeat rate is set by the 1 Hz gating in the timing block.
REQ-023 On any FSM state change, all adjustment outputs SHALL be 0 in the cycle after the change and SHALL stay 0 until UP/DOWN has been debounced low at least once in the new state, so a held key does not carry into a new field.
REQ-024 SET_EN and FIELD SHALL be registered and decoded directly from the FSM state.
REQ-025 Counter widths SHALL be sized with $clog2 of the parameters; the counters SHALL never wrap past their terminal counts.

Reset
REQ-026 While CR=0: FSM=RUN, all synchronizer flops, debounced levels and counters =0, all adjustment outputs =0, SET_EN=0, FIELD=00.
REQ-027 Reset assertion mid-debounce or mid-set SHALL take effect immediately, independent of CP.
REQ-028 After CR deasserts, a key already held high SHALL need the full DEB_CNT before it is recognized.

Verification
REQ-029 DEB_CNT=4: KEY_MODE high for 3 cycles, then low -> FSM stays RUN, FIELD=00.
REQ-030 DEB_CNT=4: three clean mode presses -> FIELD sequence 01, 10, 11 with SET_EN=1; a fourth press -> FIELD=00, SET_EN=0.
REQ-031 In SET_M, hold KEY_UP for 50 cycles -> M_UP=1 from sync+debounce+1 cycles after the press until the release is debounced; all other outputs stay 0. Hold UP and DOWN together -> M_UP=M_DOWN=0.
REQ-032 TIMEOUT=100, in SET_S with no keys -> FSM returns to RUN exactly 100 cycles after the last activity. A mode press in the timeout cycle -> RUN via the normal advance (the advance from SET_S), with no double step.
REQ-033 In SET_H, hold KEY_UP and press KEY_MODE -> FSM goes to SET_M with M_UP=0 until KEY_UP is released and pressed again.
REQ-034 Pull CR low mid-SET_M with KEY_DOWN held -> outputs clear asynchronously. After release -> RUN, and M_DOWN stays 0.
